// File: rtl/pwm_pkg.sv
// pwm_pkg: register map, defaults and the shared register bundle
// for the PWM peripheral and its timebase.
package pwm_pkg;

  localparam logic [6:0] ADDR_EN_LO  = 7'h00;
  localparam logic [6:0] ADDR_EN_HI  = 7'h01;
  localparam logic [6:0] ADDR_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY   = 7'h04;

  localparam int DEF_MAX_ADDR = 4;
  localparam int DEF_CLK_DIV  = 10;

  typedef struct packed {
    logic [15:0] en_out;
    logic [15:0] pwm_en;
    logic [7:0]  duty;
  } pwm_regs_t;

  // 0xFF is a true 100% duty, not 255/256
  function automatic logic pwm_level(
    input logic [7:0] cnt,
    input logic [7:0] duty
  );
    return (duty == 8'hFF) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_if.sv
// pwm_if: decoded register-write strobe from the SPI front end.
// Write-only, single-cycle, no backpressure.
interface pwm_if;

  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_valid,
    input wr_addr,
    input wr_data
  );

endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: clock prescaler and 8-bit PWM counter.
// wrap is high on the cycle whose edge moves the counter 255->0.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] cnt,
  output logic       wrap
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] prescaler;
  logic          tick;

  assign tick = (prescaler == PS_LAST);
  assign wrap = tick && (cnt == 8'hFF);

  // prescaler divides clk; counter advances once per tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      cnt       <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: register bank, duty shadow and 16-pin output mux.
// Define PWM_SHADOW_EN to defer duty changes to the period boundary.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int MAX_ADDR = DEF_MAX_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  pwm_if.slave        bus,
  output logic [15:0] out,
  output logic        period_start,
  output logic [7:0]  duty_active
);

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  pwm_regs_t  regs;
  logic [7:0] cnt;
  logic       wrap;
  logic       lvl;
  logic       wr_hit;

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk (clk),
    .rst (rst),
    .cnt (cnt),
    .wrap(wrap)
  );

  assign wr_hit = bus.wr_valid && (bus.wr_addr <= MAX_A);

  // register bank; out-of-range addresses are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (wr_hit) begin
      case (bus.wr_addr)
        ADDR_EN_LO:  regs.en_out[7:0]  <= bus.wr_data;
        ADDR_EN_HI:  regs.en_out[15:8] <= bus.wr_data;
        ADDR_PWM_LO: regs.pwm_en[7:0]  <= bus.wr_data;
        ADDR_PWM_HI: regs.pwm_en[15:8] <= bus.wr_data;
        ADDR_DUTY:   regs.duty         <= bus.wr_data;
        default: ;
      endcase
    end
  end

`ifdef PWM_SHADOW_EN
  logic [7:0] active_q;

  // regs.duty acts as the shadow; it is applied only at the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) active_q <= '0;
    else if (wrap) active_q <= regs.duty;
  end

  assign duty_active = active_q;
`else
  assign duty_active = regs.duty;
`endif

  assign lvl = pwm_level(cnt, duty_active);

  // registered pin drive and period strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= regs.en_out & (~regs.pwm_en | {16{lvl}});
      period_start <= wrap;
    end
  end

endmodule
